// File: rtl/bitwise_operand_loader.sv
// ============================================================================
// bitwise_operand_loader : byte-serial A/B operand assembler with valid/ready
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module bitwise_operand_loader #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_sof,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err,
    output logic [15:0]      frame_cnt
);

    localparam int NBYTES = WIDTH / 8;
    localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [IDXW-1:0] C_LAST_IDX  = IDXW'(NBYTES - 1);
    localparam logic [IDXW-1:0] C_FIRST_IDX = IDXW'((NBYTES > 1) ? 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // A single-byte operand is complete after byte0, so the frame skips LOAD_A.
    localparam state_t C_FIRST_STATE = (NBYTES > 1) ? LOAD_A : LOAD_B;

    state_t           r_state;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;

    logic             w_accept;
    logic [WIDTH-1:0] w_first;
    logic [WIDTH-1:0] w_sa_ins;
    logic [WIDTH-1:0] w_sb_ins;

    assign in_ready = (r_state != HOLD);
    assign w_accept = in_valid & in_ready;
    assign w_first  = WIDTH'(in_data);

    always_comb begin
        w_sa_ins = r_sa;
        w_sb_ins = r_sb;
        w_sa_ins[{r_idx, 3'b000} +: 8] = in_data;
        w_sb_ins[{r_idx, 3'b000} +: 8] = in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_sa      <= '0;
            r_sb      <= '0;
            a         <= '0;
            b         <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (in_sof) begin
                            r_sa    <= w_first;
                            r_sb    <= '0;
                            r_idx   <= C_FIRST_IDX;
                            r_state <= C_FIRST_STATE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                LOAD_A: begin
                    if (w_accept) begin
                        if (in_sof) begin
                            // Resync: restart the frame with this byte as A byte0.
                            err     <= 1'b1;
                            r_sa    <= w_first;
                            r_sb    <= '0;
                            r_idx   <= C_FIRST_IDX;
                            r_state <= C_FIRST_STATE;
                        end else begin
                            r_sa <= w_sa_ins;
                            if (r_idx == C_LAST_IDX) begin
                                r_idx   <= '0;
                                r_state <= LOAD_B;
                            end else begin
                                r_idx <= r_idx + IDXW'(1);
                            end
                        end
                    end
                end

                LOAD_B: begin
                    if (w_accept) begin
                        if (in_sof) begin
                            err     <= 1'b1;
                            r_sa    <= w_first;
                            r_sb    <= '0;
                            r_idx   <= C_FIRST_IDX;
                            r_state <= C_FIRST_STATE;
                        end else begin
                            r_sb <= w_sb_ins;
                            if (r_idx == C_LAST_IDX) begin
                                // Final B byte goes straight to b in the same edge.
                                a         <= r_sa;
                                b         <= w_sb_ins;
                                out_valid <= 1'b1;
                                r_idx     <= '0;
                                r_state   <= HOLD;
                            end else begin
                                r_idx <= r_idx + IDXW'(1);
                            end
                        end
                    end
                end

                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        frame_cnt <= frame_cnt + 16'd1;
                        r_state   <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bitwise_operand_loader.sv
// ============================================================================
// tb_bitwise_operand_loader : directed self-checking bench for the loader
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_bitwise_operand_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_sof;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic        err;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    bitwise_operand_loader #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one byte for exactly one edge; returns 1ns after that edge.
    task automatic put(input logic sof, input logic [7:0] d);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_sof    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        idle(2);
        chk("rst_a", 32'(a), 32'h0);
        chk("rst_b", 32'(b), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        rst = 1'b0;
        idle(1);

        // Basic frame, held until consumed
        put(1'b1, 8'h34);
        put(1'b0, 8'h12);
        put(1'b0, 8'h78);
        chk("f1_no_valid_early", 32'(out_valid), 32'h0);
        chk("f1_a_not_yet", 32'(a), 32'h0);
        put(1'b0, 8'h56);
        chk("f1_out_valid", 32'(out_valid), 32'h1);
        chk("f1_in_ready", 32'(in_ready), 32'h0);
        chk("f1_a", 32'(a), 32'h1234);
        chk("f1_b", 32'(b), 32'h5678);
        idle(2);
        chk("f1_hold_valid", 32'(out_valid), 32'h1);
        chk("f1_hold_cnt", 32'(frame_cnt), 32'h0);
        consume();
        chk("f1_consumed_valid", 32'(out_valid), 32'h0);
        chk("f1_frame_cnt", 32'(frame_cnt), 32'h1);
        chk("f1_in_ready_after", 32'(in_ready), 32'h1);

        // Orphan bytes in IDLE: one err cycle per byte, back-to-back
        put(1'b0, 8'hAA);
        chk("orphan_err1", 32'(err), 32'h1);
        chk("orphan_a_kept", 32'(a), 32'h1234);
        put(1'b0, 8'h55);
        chk("orphan_err2", 32'(err), 32'h1);
        idle(1);
        chk("orphan_err_clear", 32'(err), 32'h0);
        chk("orphan_in_ready", 32'(in_ready), 32'h1);
        put(1'b1, 8'hBB);
        put(1'b0, 8'hAA);
        put(1'b0, 8'hDD);
        put(1'b0, 8'hCC);
        chk("f2_a", 32'(a), 32'hAABB);
        chk("f2_b", 32'(b), 32'hCCDD);
        chk("f2_err", 32'(err), 32'h0);
        consume();
        chk("f2_frame_cnt", 32'(frame_cnt), 32'h2);

        // Mid-frame resync
        put(1'b1, 8'h11);
        put(1'b0, 8'h22);
        put(1'b1, 8'h34);
        chk("resync_err", 32'(err), 32'h1);
        chk("resync_a_kept", 32'(a), 32'hAABB);
        chk("resync_valid", 32'(out_valid), 32'h0);
        put(1'b0, 8'h12);
        chk("resync_err_clear", 32'(err), 32'h0);
        put(1'b0, 8'h78);
        chk("resync_b_kept", 32'(b), 32'hCCDD);
        put(1'b0, 8'h56);
        chk("resync_a", 32'(a), 32'h1234);
        chk("resync_b", 32'(b), 32'h5678);
        chk("resync_valid_set", 32'(out_valid), 32'h1);

        // sof presented in HOLD is not accepted
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_data  = 8'h99;
        idle(1);
        chk("hold_ignore_err", 32'(err), 32'h0);
        chk("hold_ignore_a", 32'(a), 32'h1234);
        chk("hold_ignore_valid", 32'(out_valid), 32'h1);
        // Consume with a byte still offered: byte must not be taken
        consume();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        chk("sim_consume_valid", 32'(out_valid), 32'h0);
        chk("sim_consume_cnt", 32'(frame_cnt), 32'h3);
        chk("sim_consume_err", 32'(err), 32'h0);
        put(1'b0, 8'h12);
        chk("sim_byte_not_taken", 32'(err), 32'h1);
        idle(1);

        // Gapped input
        put(1'b1, 8'hFF);
        idle(3);
        put(1'b0, 8'hFF);
        idle(3);
        put(1'b0, 8'h00);
        idle(3);
        chk("gap_no_valid", 32'(out_valid), 32'h0);
        chk("gap_in_ready", 32'(in_ready), 32'h1);
        put(1'b0, 8'h00);
        chk("gap_valid", 32'(out_valid), 32'h1);
        chk("gap_a", 32'(a), 32'hFFFF);
        chk("gap_b", 32'(b), 32'h0000);
        consume();
        chk("gap_frame_cnt", 32'(frame_cnt), 32'h4);

        // Asynchronous reset in LOAD_B
        put(1'b1, 8'h01);
        put(1'b0, 8'h00);
        put(1'b0, 8'h02);
        rst = 1'b1;
        #1;
        chk("arst_a", 32'(a), 32'h0);
        chk("arst_b", 32'(b), 32'h0);
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_frame_cnt", 32'(frame_cnt), 32'h0);
        chk("arst_in_ready", 32'(in_ready), 32'h1);
        idle(1);
        rst = 1'b0;
        put(1'b0, 8'h00);
        chk("arst_partial_dropped", 32'(err), 32'h1);
        put(1'b1, 8'h01);
        put(1'b0, 8'h00);
        put(1'b0, 8'h02);
        put(1'b0, 8'h00);
        chk("arst_f_a", 32'(a), 32'h0001);
        chk("arst_f_b", 32'(b), 32'h0002);
        consume();
        chk("arst_f_cnt", 32'(frame_cnt), 32'h1);

        // Counter wrap
        force dut.frame_cnt = 16'hFFFF;
        idle(1);
        release dut.frame_cnt;
        idle(1);
        chk("wrap_preload", 32'(frame_cnt), 32'hFFFF);
        put(1'b1, 8'hEF);
        put(1'b0, 8'hBE);
        put(1'b0, 8'hAD);
        put(1'b0, 8'hDE);
        chk("wrap_a", 32'(a), 32'hBEEF);
        chk("wrap_b", 32'(b), 32'hDEAD);
        consume();
        chk("wrap_cnt", 32'(frame_cnt), 32'h0000);
        chk("wrap_valid", 32'(out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
